seg_scan_mux: RTL and testbench

Parametrised multiplexed seven-segment driver for N common-anode digits on the Nexys3 display path. It scans one digit per slot and samples its inputs once per frame, so a frame never shows a mix of old and new values. Beyond plain hex display, it adds per-digit decimal points, per-digit enable, leading-zero blanking, per-digit blink and 16-level PWM brightness. It sits between the datapath/debug registers and the board's `seg`/`an` pins.

---
 rtl/seg_scan_mux.sv | 206 ++++++++++++++++++++
 tb/tb_seg_scan_mux.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_mux.sv
// Multiplexed seven-segment driver for NUM_DIGITS common-anode digits.
// Samples its inputs once per frame; adds dp, enable, leading-zero blanking, blink and PWM brightness.
module seg_scan_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int PHASE_CYCLES = 625,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   blink,
    input  logic                    lz_blank,
    input  logic [3:0]              brightness,
    output logic [7:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);
    localparam int PRE_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PHASE_CYCLES - 1);
    localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'h40;
            4'h1:    g = 7'h79;
            4'h2:    g = 7'h24;
            4'h3:    g = 7'h30;
            4'h4:    g = 7'h19;
            4'h5:    g = 7'h12;
            4'h6:    g = 7'h02;
            4'h7:    g = 7'h78;
            4'h8:    g = 7'h00;
            4'h9:    g = 7'h10;
            4'hA:    g = 7'h08;
            4'hB:    g = 7'h03;
            4'hC:    g = 7'h46;
            4'hD:    g = 7'h21;
            4'hE:    g = 7'h06;
            4'hF:    g = 7'h0E;
            default: g = 7'h7F;
        endcase
        return g;
    endfunction

    logic [PRE_W-1:0]        pre_q, pre_d;
    logic [3:0]              phase_q, phase_d;
    logic [DIG_W-1:0]        digit_q, digit_d;
    logic [FRM_W-1:0]        frame_q, frame_d;
    logic                    blink_phase_q, blink_phase_d;
    logic                    first_q, first_d;

    logic [4*NUM_DIGITS-1:0] val_snap_q, val_snap_d;
    logic [NUM_DIGITS-1:0]   dp_snap_q, dp_snap_d;
    logic [NUM_DIGITS-1:0]   en_snap_q, en_snap_d;
    logic [NUM_DIGITS-1:0]   blink_snap_q, blink_snap_d;
    logic                    lz_snap_q, lz_snap_d;
    logic [3:0]              bright_snap_q, bright_snap_d;

    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frame_start_q, frame_start_d;

    logic                    pre_wrap_s, slot_end_s, boundary_s;
    logic [NUM_DIGITS-1:0]   lz_dark_s;
    logic [3:0]              nib_s;
    logic                    cur_lz_s, cur_dp_s, lit_s;

    // Scan counters, frame/blink bookkeeping and frame-boundary snapshot loading.
    always_comb begin
        pre_wrap_s = (pre_q == PRE_LAST);
        slot_end_s = pre_wrap_s && (phase_q == 4'd15);
        boundary_s = slot_end_s && (digit_q == '0);

        if (pre_wrap_s) begin
            pre_d   = '0;
            phase_d = phase_q + 4'd1;
        end else begin
            pre_d   = pre_q + PRE_W'(1);
            phase_d = phase_q;
        end

        if (slot_end_s) begin
            if (digit_q == '0) begin
                digit_d = DIG_LAST;
            end else begin
                digit_d = digit_q - DIG_W'(1);
            end
        end else begin
            digit_d = digit_q;
        end

        frame_d       = frame_q;
        blink_phase_d = blink_phase_q;
        first_d       = first_q;
        // The boundary right after reset opens frame 0 rather than closing a frame.
        if (boundary_s) begin
            if (first_q) begin
                first_d = 1'b0;
            end else if (frame_q == FRM_LAST) begin
                frame_d       = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                frame_d = frame_q + FRM_W'(1);
            end
        end else begin
            first_d = first_q;
        end

        if (boundary_s) begin
            val_snap_d    = value;
            dp_snap_d     = dp;
            en_snap_d     = digit_en;
            blink_snap_d  = blink;
            lz_snap_d     = lz_blank;
            bright_snap_d = brightness;
        end else begin
            val_snap_d    = val_snap_q;
            dp_snap_d     = dp_snap_q;
            en_snap_d     = en_snap_q;
            blink_snap_d  = blink_snap_q;
            lz_snap_d     = lz_snap_q;
            bright_snap_d = bright_snap_q;
        end
    end

    // Per-slot display decode from the current counters and the frame snapshot.
    always_comb begin
        logic zero_run;
        zero_run  = 1'b1;
        lz_dark_s = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run     = zero_run && (val_snap_q[4*i +: 4] == 4'h0);
            lz_dark_s[i] = (i != 0) && lz_snap_q && zero_run;
        end

        nib_s    = val_snap_q[{digit_q, 2'b00} +: 4];
        cur_lz_s = lz_dark_s[digit_q];
        cur_dp_s = dp_snap_q[digit_q];
        lit_s    = en_snap_q[digit_q]
                 && !(blink_snap_q[digit_q] && blink_phase_q)
                 && !(cur_lz_s && !cur_dp_s)
                 && (phase_q <= bright_snap_q);

        an_d = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            an_d[i] = ~(lit_s && (digit_q == DIG_W'(i)));
        end

        if (lit_s) begin
            seg_d = {~cur_dp_s, (cur_lz_s ? 7'h7F : hex_glyph(nib_s))};
        end else begin
            seg_d = 8'hFF;
        end

        frame_start_d = boundary_s;
    end

    // State and output registers; reset parks the counters on a frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q         <= PRE_LAST;
            phase_q       <= 4'd15;
            digit_q       <= '0;
            frame_q       <= '0;
            blink_phase_q <= 1'b0;
            first_q       <= 1'b1;
            val_snap_q    <= '0;
            dp_snap_q     <= '0;
            en_snap_q     <= '0;
            blink_snap_q  <= '0;
            lz_snap_q     <= 1'b0;
            bright_snap_q <= 4'd0;
            seg_q         <= 8'hFF;
            an_q          <= '1;
            frame_start_q <= 1'b0;
        end else begin
            pre_q         <= pre_d;
            phase_q       <= phase_d;
            digit_q       <= digit_d;
            frame_q       <= frame_d;
            blink_phase_q <= blink_phase_d;
            first_q       <= first_d;
            val_snap_q    <= val_snap_d;
            dp_snap_q     <= dp_snap_d;
            en_snap_q     <= en_snap_d;
            blink_snap_q  <= blink_snap_d;
            lz_snap_q     <= lz_snap_d;
            bright_snap_q <= bright_snap_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg         = seg_q;
    assign an          = an_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux: 4 digits, 2-cycle phases (32-cycle slots, 128-cycle frames), 2-frame blink.
module tb_seg_scan_mux;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  digit_en;
    logic [3:0]  blink;
    logic        lz_blank;
    logic [3:0]  brightness;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_start;

    int n_cmp = 0;
    int n_bad = 0;
    int fr    = 0;

    always #5 clk = ~clk;

    seg_scan_mux #(
        .NUM_DIGITS   (4),
        .PHASE_CYCLES (2),
        .BLINK_FRAMES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value       (value),
        .dp          (dp),
        .digit_en    (digit_en),
        .blink       (blink),
        .lz_blank    (lz_blank),
        .brightness  (brightness),
        .seg         (seg),
        .an          (an),
        .frame_start (frame_start)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_slot(input string tag, input logic [3:0] a, input logic [7:0] s);
        chk({tag, "_an"}, {12'd0, an}, {12'd0, a});
        chk({tag, "_seg"}, {8'd0, seg}, {8'd0, s});
    endtask

    task automatic chk_fs(input string tag, input logic e);
        chk(tag, {15'd0, frame_start}, {15'd0, e});
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Advance to the sample point just after the next frame boundary edge.
    task automatic wait_frame();
        logic seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            step(1);
            seen = frame_start;
        end
        chk("frame_wait", {15'd0, seen}, 16'd1);
        fr++;
    endtask

    initial begin
        logic [3:0] exp_an [4];
        logic [7:0] exp_seg [4];
        logic       lit;
        exp_an  = '{4'h7, 4'hB, 4'hD, 4'hE};
        exp_seg = '{8'hF9, 8'h24, 8'h88, 8'h83};

        rst_n = 1'b0; value = 16'h12AB; dp = 4'b0100; digit_en = 4'hF;
        blink = 4'b0000; lz_blank = 1'b0; brightness = 4'd15;
        step(3);
        chk_slot("reset", 4'hF, 8'hFF);
        chk_fs("reset_fs", 1'b0);
        #2 rst_n = 1'b1;
        step(1);
        chk_fs("release_fs", 1'b1);

        // Frame 0: scan order MSD first, glyphs and dp.
        for (int s = 0; s < 4; s++) begin
            step(1);
            chk_fs("fs_low", 1'b0);
            chk_slot("scan_c0", exp_an[s], exp_seg[s]);
            step(31);
            chk_slot("scan_c31", exp_an[s], exp_seg[s]);
        end
        chk_fs("fs_period", 1'b1);
        fr = 1;

        // Tear-free: change arrives mid slot 2 of frame 2.
        value = 16'h1111;
        wait_frame();
        step(70);
        value = 16'h2222;
        step(15);
        chk_slot("tear_s2", 4'hD, 8'hF9);
        step(22);
        chk_slot("tear_s3", 4'hE, 8'hF9);
        wait_frame();
        step(1);
        chk_slot("new_s0", 4'h7, 8'hA4);
        step(32);
        chk_slot("new_s1", 4'hB, 8'h24);
        step(32);
        chk_slot("new_s2", 4'hD, 8'hA4);
        step(32);
        chk_slot("new_s3", 4'hE, 8'hA4);

        // Brightness 3: lit phases 0-3 = 8 cycles of each slot.
        brightness = 4'd3;
        wait_frame();
        step(8);
        chk_slot("br3_c7", 4'h7, 8'hA4);
        step(1);
        chk_slot("br3_c8", 4'hF, 8'hFF);
        step(23);
        chk_slot("br3_c31", 4'hF, 8'hFF);
        step(1);
        chk_slot("br3_s1c0", 4'hB, 8'h24);
        brightness = 4'd0;
        wait_frame();
        step(34);
        chk_slot("br0_c1", 4'hB, 8'h24);
        step(1);
        chk_slot("br0_c2", 4'hF, 8'hFF);

        // Leading-zero blanking.
        brightness = 4'd15; lz_blank = 1'b1; value = 16'h0050; dp = 4'b0000;
        wait_frame();
        step(11);
        chk_slot("lz_d3", 4'hF, 8'hFF);
        step(32);
        chk_slot("lz_d2", 4'hF, 8'hFF);
        step(32);
        chk_slot("lz_d1", 4'hD, 8'h92);
        step(32);
        chk_slot("lz_d0", 4'hE, 8'hC0);
        value = 16'h0000;
        wait_frame();
        step(11);
        chk_slot("lz0_d3", 4'hF, 8'hFF);
        step(32);
        chk_slot("lz0_d2", 4'hF, 8'hFF);
        step(32);
        chk_slot("lz0_d1", 4'hF, 8'hFF);
        step(32);
        chk_slot("lz0_d0", 4'hE, 8'hC0);
        dp = 4'b1000;
        wait_frame();
        step(11);
        chk_slot("lzdp_d3", 4'h7, 8'h7F);
        step(32);
        chk_slot("lzdp_d2", 4'hF, 8'hFF);
        step(64);
        chk_slot("lzdp_d0", 4'hE, 8'hC0);

        // Blink on digit 0: lit when (frame/2) is even.
        blink = 4'b0001; lz_blank = 1'b0; value = 16'h12AB; dp = 4'b0000;
        for (int f = 0; f < 5; f++) begin
            wait_frame();
            lit = (((fr / 2) % 2) == 0);
            step(11);
            chk_slot("blink_d3", 4'h7, 8'hF9);
            step(96);
            chk_slot("blink_d0", lit ? 4'hE : 4'hF, lit ? 8'h83 : 8'hFF);
        end

        // Asynchronous reset mid-slot, then restart at a frame boundary.
        wait_frame();
        step(43);
        chk_slot("pre_rst", 4'hB, 8'hA4);
        #3 rst_n = 1'b0;
        #1;
        chk_slot("async_rst", 4'hF, 8'hFF);
        chk_fs("async_rst_fs", 1'b0);
        #2 rst_n = 1'b1;
        step(1);
        chk_fs("restart_fs", 1'b1);
        step(1);
        chk_fs("restart_fs_low", 1'b0);
        chk_slot("restart_s0", 4'h7, 8'hF9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
